// File: rtl/logic_gate_pkg.sv
// Shared types and widths for the logic_gate_pipe block.
package logic_gate_pkg;

    localparam int MODE_W = 2;
    localparam int STAT_W = 32;

    typedef enum logic [MODE_W-1:0] {
        GM_AND_OR   = 2'd0,
        GM_NAND_NOR = 2'd1,
        GM_XOR_XNOR = 2'd2,
        GM_PASS     = 2'd3
    } gate_mode_e;

endpackage

// File: rtl/logic_gate_fifo.sv
// Generic synchronous queue with occupancy count and wrapping pointers.
// The head entry is presented combinationally from storage.
module logic_gate_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; stale entries are masked by the count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/logic_gate_pipe.sv
// Selectable bitwise gate pair over NUM_CH channels, queued behind valid/ready.
// Optional accept counter enabled by defining LOGIC_GATE_PIPE_STATS_EN.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_a,
    input  logic [NUM_CH*WIDTH-1:0] in_b,
    input  logic [MODE_W-1:0]       in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_and,
    output logic [NUM_CH*WIDTH-1:0] out_or,
    output logic [NUM_CH-1:0]       out_nz
`ifdef LOGIC_GATE_PIPE_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [STAT_W-1:0]       stat_count
`endif
);

    localparam int VEC_W = NUM_CH * WIDTH;
    localparam int ENT_W = 2 * VEC_W + NUM_CH;

    gate_mode_e        mode_p0;
    logic [VEC_W-1:0]  and_p0;
    logic [VEC_W-1:0]  or_p0;
    logic [NUM_CH-1:0] nz_p0;
    logic [ENT_W-1:0]  head_p1;
    logic              full;
    logic              empty;
    logic              accept;

    // Stage p0: gate functions and nz reduction on the live operands
    always_comb begin
        mode_p0 = gate_mode_e'(in_mode);
        and_p0  = '0;
        or_p0   = '0;
        nz_p0   = '0;
        case (mode_p0)
            GM_AND_OR: begin
                and_p0 = in_a & in_b;
                or_p0  = in_a | in_b;
            end
            GM_NAND_NOR: begin
                and_p0 = ~(in_a & in_b);
                or_p0  = ~(in_a | in_b);
            end
            GM_XOR_XNOR: begin
                and_p0 = in_a ^ in_b;
                or_p0  = ~(in_a ^ in_b);
            end
            default: begin
                and_p0 = in_a;
                or_p0  = in_b;
            end
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            nz_p0[c] = |and_p0[c*WIDTH +: WIDTH];
        end
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;

    // Stage p1: queued result, head presented to the consumer
    logic_gate_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data ({and_p0, or_p0, nz_p0}),
        .rd_en   (out_ready),
        .rd_data (head_p1),
        .full    (full),
        .empty   (empty)
    );

    assign out_and = out_valid ? head_p1[ENT_W-1 -: VEC_W]      : '0;
    assign out_or  = out_valid ? head_p1[NUM_CH +: VEC_W]       : '0;
    assign out_nz  = out_valid ? head_p1[NUM_CH-1:0]            : '0;

`ifdef LOGIC_GATE_PIPE_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        stat_count <= '0;
        else if (stat_clr) stat_count <= '0;
        else if (accept)   stat_count <= sat_inc(stat_count);
    end
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe with a queue-based reference model.
// Stat counter checks are included when LOGIC_GATE_PIPE_STATS_EN is defined.
module tb_logic_gate_pipe;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 2;
    localparam int VEC_W  = WIDTH * NUM_CH;
    localparam int ENT_W  = 2 * VEC_W + NUM_CH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [VEC_W-1:0]  in_a = '0;
    logic [VEC_W-1:0]  in_b = '0;
    logic [1:0]        in_mode = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [VEC_W-1:0]  out_and;
    logic [VEC_W-1:0]  out_or;
    logic [NUM_CH-1:0] out_nz;
`ifdef LOGIC_GATE_PIPE_STATS_EN
    logic              stat_clr = 1'b0;
    logic [31:0]       stat_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic_gate_pipe #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_and   (out_and),
        .out_or    (out_or),
        .out_nz    (out_nz)
`ifdef LOGIC_GATE_PIPE_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_count(stat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: result triple computed straight from the mode table
    function automatic logic [ENT_W-1:0] gate_ref(input logic [VEC_W-1:0] a,
                                                  input logic [VEC_W-1:0] b,
                                                  input int m);
        logic [VEC_W-1:0]  p, s;
        logic [NUM_CH-1:0] nz;
        logic [WIDTH-1:0]  ch;
        case (m)
            0:       begin p = a & b;     s = a | b;     end
            1:       begin p = ~(a & b);  s = ~(a | b);  end
            2:       begin p = a ^ b;     s = ~(a ^ b);  end
            default: begin p = a;         s = b;         end
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            ch    = p[c*WIDTH +: WIDTH];
            nz[c] = (ch != 0);
        end
        return {p, s, nz};
    endfunction

    logic [ENT_W-1:0] model_q[$];
    int               pops_seen = 0;
    longint           model_stat = 0;

    always @(posedge clk or negedge rst_n) begin
        bit do_push, do_pop;
        if (!rst_n) begin
            model_q.delete();
            model_stat = 0;
        end else begin
            do_push = in_valid && (model_q.size() < DEPTH);
            do_pop  = (model_q.size() != 0) && out_ready;
            if (do_pop) begin
                void'(model_q.pop_front());
                pops_seen++;
            end
            if (do_push) model_q.push_back(gate_ref(in_a, in_b, int'(in_mode)));
`ifdef LOGIC_GATE_PIPE_STATS_EN
            if (stat_clr)     model_stat = 0;
            else if (do_push) model_stat = (model_stat == 64'hFFFF_FFFF) ? model_stat : model_stat + 1;
`endif
        end
    end

    always @(negedge clk) begin
        logic [ENT_W-1:0] exp_e;
        exp_e = (model_q.size() != 0) ? model_q[0] : '0;
        chk("in_ready",  in_ready,  model_q.size() < DEPTH);
        chk("out_valid", out_valid, model_q.size() != 0);
        chk("out_and",   out_and,   exp_e[ENT_W-1 -: VEC_W]);
        chk("out_or",    out_or,    exp_e[NUM_CH +: VEC_W]);
        chk("out_nz",    out_nz,    exp_e[NUM_CH-1:0]);
`ifdef LOGIC_GATE_PIPE_STATS_EN
        chk("stat_count", stat_count, model_stat);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                       input logic [1:0] m);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
    endtask

    initial begin
        int pops_before;
        #1 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_and",   out_and,   '0);
        chk("rst_out_nz",    out_nz,    '0);

        // Mode 0 across all channels
        step();
        out_ready = 1'b1;
        put(1'b1, 32'hF0F0_0F00, 32'hFF00_FF00, 2'd0);
        step();
        put(1'b0, '0, '0, 2'd0);
        @(negedge clk);
        chk("m0_and",   out_and,   32'hF000_0F00);
        chk("m0_or",    out_or,    32'hFFF0_FF00);
        chk("m0_nz",    out_nz,    4'b1010);
        chk("m0_valid", out_valid, 1'b1);
        step();
        @(negedge clk);
        chk("m0_drop", out_valid, 1'b0);

        // Modes 1..3 on channel 0
        for (int m = 1; m < 4; m++) begin
            step();
            put(1'b1, 32'h0000_00AA, 32'h0000_000F, 2'(m));
            step();
            put(1'b0, '0, '0, 2'd0);
            @(negedge clk);
            case (m)
                1: begin chk("m1_and", out_and[7:0], 8'hF5); chk("m1_or", out_or[7:0], 8'h50); end
                2: begin chk("m2_and", out_and[7:0], 8'hA5); chk("m2_or", out_or[7:0], 8'h5A); end
                default: begin chk("m3_and", out_and[7:0], 8'hAA); chk("m3_or", out_or[7:0], 8'h0F); end
            endcase
        end
        step();
        step();

        // Backpressure: third set refused until the first pop
        out_ready = 1'b0;
        put(1'b1, 32'h0000_0011, 32'h0000_0001, 2'd3);
        step();
        put(1'b1, 32'h0000_0022, 32'h0000_0002, 2'd3);
        step();
        put(1'b1, 32'h0000_0033, 32'h0000_0003, 2'd3);
        @(negedge clk);
        chk("bp_full_ready", in_ready, 1'b0);
        chk("bp_head",       out_and,  32'h0000_0011);
        step();
        @(negedge clk);
        chk("bp_still_full", in_ready, 1'b0);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_ready_back", in_ready, 1'b1);
        chk("bp_second",     out_and,  32'h0000_0022);
        step();
        put(1'b0, '0, '0, 2'd0);
        @(negedge clk);
        chk("bp_third", out_and, 32'h0000_0033);
        step();
        step();

        // Continuous streaming
        pops_before = pops_seen;
        for (int i = 0; i < 64; i++) begin
            put(1'b1, VEC_W'(i * 32'h0101_0101), VEC_W'(32'h0F0F_0F0F ^ i), 2'(i % 4));
            step();
        end
        put(1'b0, '0, '0, 2'd0);
        step();
        step();
        chk("stream_pops", pops_seen - pops_before, 64);

        // Reset while two entries are queued
        out_ready = 1'b0;
        put(1'b1, 32'h1234_5678, 32'h8765_4321, 2'd0);
        step();
        step();
        put(1'b0, '0, '0, 2'd0);
        @(negedge clk);
        chk("pre_rst_full", in_ready, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_ready", in_ready,  1'b1);
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("post_rst_empty", out_valid, 1'b0);

`ifdef LOGIC_GATE_PIPE_STATS_EN
        chk("stat_after_rst", stat_count, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            put(1'b1, VEC_W'(i + 1), '0, 2'd3);
        end
        step();
        put(1'b0, '0, '0, 2'd0);
        @(negedge clk);
        chk("stat_five", stat_count, 32'd5);
        step();
        stat_clr = 1'b1;
        put(1'b1, 32'h1, 32'h1, 2'd0);
        step();
        stat_clr = 1'b0;
        put(1'b0, '0, '0, 2'd0);
        @(negedge clk);
        chk("stat_clr", stat_count, 32'd0);
`endif
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
